clap_sequencer: RTL and testbench
=================================

# clap_sequencer

Controller that sequences the clap counter datapath. It watches the 4-bit clap total and groups claps into a burst using an inter-clap gap timeout. At the end of a burst it issues one decoded command, clears the counter, and optionally locks out re-triggering. It sits between the clap counter and the light/output logic, and owns the counter's clear line.

## Interface
- GAP_CYCLES, default 25_000_000: idle cycles after the last clap that close a burst (≥2).
- MAX_CLAPS, default 4: clap total that closes a burst immediately (1..15).
- LOCKOUT_CYCLES, default 50_000_000: post-command dead time (≥1); used only with the lockout feature.
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clap_count  input  4  running total from the clap counter; synchronous to clk.
- counter_clr  output  1  registered, active-high clear driven into the counter's reset.
- cmd_valid  output  1  one-cycle pulse when a burst is decoded.
- cmd_code  output  4  clap total of the decoded burst; held until the next cmd_valid.
- light_on  output  1  controlled output state.
- busy  output  1  high in any state other than IDLE.

## Operation
- Reset values:
  - state = IDLE, counter_clr = 1, cmd_valid = 0, cmd_code = 0, light_on = 0, busy = 0.
  - Timer = 0, prev_count = 0.
- Registered outputs only; no combinational path from clap_count to any output.
- prev_count holds the last sampled clap_count. A "clap event" is clap_count != prev_count.
- IDLE:
  - counter_clr = 0.
  - On a clap event, go to COLLECT and load timer = 0.
- COLLECT:
  - Each clap event reloads timer = 0. Otherwise timer increments.
  - If clap_count ≥ MAX_CLAPS, go to DECODE at once.
  - If timer reaches GAP_CYCLES−1 with no event, go to DECODE.
- DECODE (one cycle):
  - Latch cmd_code = clap_count and pulse cmd_valid.
  - Assert counter_clr.
  - Apply the command:
    - code 2: toggle light_on.
    - code 3: force light_on = 0.
    - codes 4..15: force light_on = 1.
    - code 1: no change (noise reject). cmd_valid still pulses.
  - Next state is LOCKOUT or IDLE (see Configuration).
- LOCKOUT:
  - counter_clr held at 1 and timer increments.
  - At timer = LOCKOUT_CYCLES−1, go to IDLE. counter_clr falls on entry to IDLE.
- Boundaries:
  - Clap events during DECODE or LOCKOUT are discarded, because the counter is held clear.
  - When clap_count equals MAX_CLAPS and the gap expires in the same cycle, decode once.
  - Counter wrap (15→0) cannot occur, because MAX_CLAPS ≤ 15 closes the burst first.
  - If clap_count drops to 0 in COLLECT (external clear), go to DECODE with code 0: cmd_valid pulses and light_on is unchanged.
  - rst_n asserted mid-burst returns all state to reset values asynchronously. No command is issued.
- Timer width is $clog2 of the larger of GAP_CYCLES and LOCKOUT_CYCLES. Comparisons are unsigned.

## Timing
- Clap event at cycle N (clap_count changes at N): COLLECT is entered at N+1 and busy = 1 at N+1.
- Gap close: with the last event at cycle E, DECODE happens at E+GAP_CYCLES+1, and cmd_valid/cmd_code/light_on update at the same edge.
- MAX_CLAPS close: DECODE is one cycle after clap_count reaches MAX_CLAPS.
- counter_clr rises with cmd_valid. The counter reads 0 one cycle later.
- Lockout length: counter_clr is high for exactly LOCKOUT_CYCLES+1 cycles (DECODE plus LOCKOUT). Without the macro it is high for 1 cycle.
- After reset release: counter_clr deasserts on the first clk edge, and clap events are accepted from the second edge.

## Configuration
- CLAP_LOCKOUT_EN defined:
  - DECODE → LOCKOUT → IDLE as above.
  - LOCKOUT_CYCLES is honoured.
- CLAP_LOCKOUT_EN undefined:
  - The LOCKOUT state and its timer compare are not built.
  - DECODE → IDLE directly, with counter_clr high for one cycle only.
  - LOCKOUT_CYCLES is ignored.

## Test plan
- Two claps 5 cycles apart (GAP_CYCLES=20): cmd_valid pulse 21 cycles after the second clap, cmd_code=2, light_on 0→1, clap_count=0 the following cycle.
- Repeat the two-clap burst after lockout (LOCKOUT_CYCLES=10, macro on): light_on 1→0, counter_clr high for 11 cycles, busy falls when IDLE is re-entered.
- Four claps with MAX_CLAPS=4: DECODE one cycle after the fourth clap with no gap wait, cmd_code=4, light_on=1.
- Single clap: cmd_valid pulses with cmd_code=1 and light_on is unchanged. Claps injected during lockout produce no second cmd_valid.
- rst_n pulsed low while in COLLECT with clap_count=3: all outputs take reset values immediately, no cmd_valid, counter_clr=1 until the first edge after release.
- Macro undefined, three claps: cmd_code=3, light_on=0, counter_clr high exactly 1 cycle, a new clap accepted 2 cycles after DECODE.

Source files
------------

// File: rtl/clap_sequencer.sv
// Clap burst sequencer: groups clap-counter changes into bursts, decodes one command per burst, owns the counter clear; define CLAP_LOCKOUT_EN for post-command lockout.
// Latency: command one cycle after the burst closes (gap timeout or MAX_CLAPS); registered outputs, no backpressure.
module clap_sequencer #(
    parameter int unsigned GAP_CYCLES     = 25_000_000,
    parameter int unsigned MAX_CLAPS      = 4,
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] clap_count,
    output logic       counter_clr,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    output logic       light_on,
    output logic       busy
);

    localparam int unsigned TMAX = (GAP_CYCLES > LOCKOUT_CYCLES) ? GAP_CYCLES : LOCKOUT_CYCLES;
    localparam int          TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    MAX_CODE = 4'(MAX_CLAPS);
`ifdef CLAP_LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
`ifdef CLAP_LOCKOUT_EN
        DECODE  = 2'd2,
        LOCKOUT = 2'd3
`else
        DECODE  = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    prev_count_q, prev_count_d;
    logic          counter_clr_q, counter_clr_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [3:0]    cmd_code_q, cmd_code_d;
    logic          light_on_q, light_on_d;
    logic          busy_q, busy_d;
    logic          clap_event;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        prev_count_d  = clap_count;
        counter_clr_d = counter_clr_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        light_on_d    = light_on_q;
        clap_event    = (clap_count != prev_count_q);

        case (state_q)
            IDLE: begin
                counter_clr_d = 1'b0;
                // The counter is still being cleared on the first cycle after reset.
                if (clap_event && !counter_clr_q) begin
                    state_d = COLLECT;
                    timer_d = '0;
                end
            end
            COLLECT: begin
                if ((clap_count == 4'd0) || (clap_count >= MAX_CODE) ||
                    (!clap_event && (timer_q == GAP_LAST))) begin
                    state_d       = DECODE;
                    timer_d       = '0;
                    cmd_valid_d   = 1'b1;
                    cmd_code_d    = clap_count;
                    counter_clr_d = 1'b1;
                    if (clap_count == 4'd2) begin
                        light_on_d = ~light_on_q;
                    end else if (clap_count == 4'd3) begin
                        light_on_d = 1'b0;
                    end else if (clap_count >= 4'd4) begin
                        light_on_d = 1'b1;
                    end
                end else if (clap_event) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DECODE: begin
                // The counter reads zero next cycle; track that so the clear is not seen as a clap.
                prev_count_d = 4'd0;
                timer_d      = '0;
`ifdef CLAP_LOCKOUT_EN
                state_d       = LOCKOUT;
                counter_clr_d = 1'b1;
`else
                state_d       = IDLE;
                counter_clr_d = 1'b0;
`endif
            end
`ifdef CLAP_LOCKOUT_EN
            LOCKOUT: begin
                prev_count_d  = 4'd0;
                counter_clr_d = 1'b1;
                if (timer_q == LOCK_LAST) begin
                    state_d       = IDLE;
                    counter_clr_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            prev_count_q  <= 4'd0;
            counter_clr_q <= 1'b1;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 4'd0;
            light_on_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            prev_count_q  <= prev_count_d;
            counter_clr_q <= counter_clr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            light_on_q    <= light_on_d;
            busy_q        <= busy_d;
        end
    end

    assign counter_clr = counter_clr_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign light_on    = light_on_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_clap_sequencer.sv
// Bench for clap_sequencer: models the clap counter plus a timestamp-based burst model; a monitor checks outputs against a scoreboard.
module tb_clap_sequencer;
    localparam int GAP  = 20;
    localparam int MAXC = 4;
    localparam int LOCK = 10;
`ifdef CLAP_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] clap_count = 4'd0;
    logic       counter_clr, cmd_valid, light_on, busy;
    logic [3:0] cmd_code;

    always #5 clk = ~clk;

    clap_sequencer #(.GAP_CYCLES(GAP), .MAX_CLAPS(MAXC), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .clap_count(clap_count), .counter_clr(counter_clr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .light_on(light_on), .busy(busy)
    );

    typedef struct {int cyc; int code; bit light;} cmd_t;
    typedef struct packed {logic busy; logic clr; logic light; logic [3:0] code;} st_t;

    cmd_t cmd_q[$];
    st_t  exp_cur, exp_next;
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    int   cnt = 0;
    bit   mon_en = 1'b0;

    // Burst model in cycle timestamps: open burst, last clap time, end of clear window.
    bit m_open, m_light;
    int m_last, m_prev, m_dec, m_block, m_code;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Consumes the clap total seen in cycle t and predicts outputs for cycle t+1.
    task automatic model_step(input int t, input int c);
        bit ev;
        bit dec;
        ev  = (c != m_prev);
        dec = 1'b0;
        if (!m_open) begin
            if (t >= m_block && ev) begin
                m_open = 1'b1;
                m_last = t;
            end
        end else if (c == 0 || c >= MAXC || (!ev && (t - m_last) == GAP)) begin
            dec = 1'b1;
        end else if (ev) begin
            m_last = t;
        end
        if (dec) begin
            m_open = 1'b0;
            m_code = c;
            if (c == 2) m_light = !m_light;
            else if (c == 3) m_light = 1'b0;
            else if (c >= 4) m_light = 1'b1;
            cmd_q.push_back('{t + 1, c, m_light});
            m_dec   = t + 1;
            m_block = LOCK_EN ? t + 2 + LOCK : t + 2;
        end
        m_prev = (t >= m_dec && t < m_block) ? 0 : c;
        exp_next.busy  = m_open || (t + 1 < m_block);
        exp_next.clr   = (t + 1 < m_block);
        exp_next.light = m_light;
        exp_next.code  = 4'(m_code);
    endtask

    // One clock of the external counter: clear wins, then external clear, then a clap.
    task automatic step(input bit clap, input bit xclr);
        int nxt;
        if (counter_clr) nxt = 0;
        else if (xclr) nxt = 0;
        else if (clap) nxt = (cnt + 1) % 16;
        else nxt = cnt;
        @(posedge clk);
        #1;
        cnt        = nxt;
        clap_count = 4'(cnt);
        cyc++;
        exp_cur = exp_next;
        model_step(cyc, cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic clap();
        step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_counter_clr", counter_clr, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_light_on", light_on, 0);
        check("rst_busy", busy, 0);
        cnt        = 0;
        clap_count = 4'd0;
        cmd_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = 0;
        m_open  = 1'b0;
        m_light = 1'b0;
        m_last  = 0;
        m_prev  = 0;
        m_dec   = 1;
        m_block = 1;
        m_code  = 0;
        exp_cur = '{1'b0, 1'b1, 1'b0, 4'd0};
        model_step(0, 0);
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        cmd_t e;
        if (mon_en && rst_n) begin
            check("busy", busy, exp_cur.busy);
            check("counter_clr", counter_clr, exp_cur.clr);
            check("light_on", light_on, exp_cur.light);
            check("cmd_code_held", cmd_code, exp_cur.code);
            if (cmd_valid) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_cmd at cycle %0d: cmd_valid=1 code=%0d, expected no command", cyc, cmd_code);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_cycle", cyc, e.cyc);
                    check("cmd_code", cmd_code, e.code);
                    check("cmd_light", light_on, e.light);
                end
            end else if (cmd_q.size() > 0 && cmd_q[0].cyc <= cyc) begin
                e = cmd_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_cmd at cycle %0d: cmd_valid=0, expected code %0d at cycle %0d", cyc, e.code, e.cyc);
            end
        end
    end

    initial begin
        do_reset();
        idle(2);
        // Two claps five cycles apart: code 2, light toggles on.
        clap(); idle(4); clap(); idle(45);
        // Same burst again: light toggles off.
        clap(); idle(4); clap(); idle(45);
        // Four claps reach MAX_CLAPS and close without a gap wait.
        clap(); idle(2); clap(); clap(); idle(1); clap(); idle(30);
        // Single clap, then claps landing in the decode/clear window.
        clap(); idle(20); clap(); clap(); clap(); idle(40);
        // Reset in the middle of a three-clap burst.
        clap(); clap(); clap(); idle(3);
        do_reset();
        idle(3);
        // Three claps: code 3 forces the light off.
        clap(); idle(3); clap(); idle(3); clap(); idle(40);
        clap(); clap(); idle(25);
        clap(); idle(3); clap(); idle(3); clap(); idle(40);
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 24) step(1'b1, 1'b0);
            else if (r == 199) step(1'b0, 1'b1);
            else if (r == 198) idle(25);
            else step(1'b0, 1'b0);
        end
        idle(60);
        check("pending_cmds", cmd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
